huffman_hist_accum: RTL and testbench
=====================================

// Module: huffman_hist_accum
// PURPOSE
//  Parametrised symbol-frequency accumulator for the Huffman encoder front end. Sits between the AHB
//  slave data path and the tree builder. Takes LANES symbols per beat over a valid/ready handshake
//  and counts exactly file_size symbols into a 2**SYM_W-bin histogram.
//  Exposes a registered bin-readout port and a nonzero-bin (leaf) count for the tree builder.
// PARAMETERS
//  SYM_W   8   symbol width in bits; histogram has NBINS = 2**SYM_W bins
//  CNT_W   16  width of each bin counter
//  LANES   4   symbols per input beat; lane k = in_data[k*SYM_W +: SYM_W]; lane 0 is first in file order
//  SIZE_W  16  width of file_size / byte_count
// PORTS
//  clk         in   1               clock, rising edge
//  reset       in   1               asynchronous, active-low reset
//  clear       in   1               synchronous abort: zero histogram and counters, return to IDLE
//  start       in   1               one-cycle pulse; latches file_size and begins a run
//  file_size   in   SIZE_W          number of symbols in this run
//  in_valid    in   1               input beat valid
//  in_ready    out  1               block accepts a beat (high only in ACCUM)
//  in_data     in   LANES*SYM_W     packed symbols
//  busy        out  1               high in ACCUM
//  done        out  1               high in DONE; held until start or clear
//  byte_count  out  SIZE_W          symbols accumulated so far in this run
//  leaf_count  out  SYM_W+1         number of bins with nonzero count
//  rd_addr     in   SYM_W           bin select for readout
//  rd_data     out  CNT_W           count of bin rd_addr, registered
//  sat_flag    out  1               sticky: some bin hit saturation this run
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all bins, byte_count, remaining, rd_data, sat_flag = 0.
//    in_ready, busy, done = 0; leaf_count = 0. Reset mid-run discards the run.
//  FSM: IDLE -> ACCUM on start (file_size != 0); IDLE/DONE -> DONE directly on start with file_size == 0.
//    ACCUM -> DONE when remaining reaches 0; DONE -> ACCUM on start (file_size != 0).
//  start (IDLE or DONE): remaining <= file_size, byte_count <= 0, all bins <= 0, sat_flag <= 0, same edge.
//    start in ACCUM is ignored.
//  clear: highest priority below reset; zeroes bins, byte_count, remaining, sat_flag.
//    Goes to IDLE from any state. clear and start together: clear wins.
//  Handshake: beat consumed on the edge where in_valid & in_ready. in_data need not be held otherwise.
//    in_ready is combinational from state only (no dependence on in_valid).
//  Per beat: take = min(LANES, remaining); lanes 0..take-1 counted, remaining lanes ignored.
//    remaining -= take; byte_count += take. Last (partial) beat raises done the next cycle.
//    Exactly one cycle after the final beat edge, state is DONE.
//  Bin update: each bin adds the number of counted lanes whose symbol equals its index (0..LANES) in one cycle.
//    Duplicate symbols within a beat must all count.
//  Readout: rd_data <= bin[rd_addr] every cycle in every state (1-cycle latency).
//    Same-edge update returns the pre-update value.
//  leaf_count: combinational popcount of (bin != 0) over all bins. Valid for the tree builder when done=1.
//  Arithmetic: bin counters unsigned CNT_W; overflow handling per CONFIGURATION. byte_count never exceeds file_size.
// CONFIGURATION
//  HUFF_HIST_SATURATE_EN defined: a bin whose sum exceeds 2**CNT_W-1 clamps to 2**CNT_W-1.
//    sat_flag sets the same edge and stays set until start/clear/reset.
//  Not defined: bins wrap modulo 2**CNT_W; sat_flag tied to 0.
// TESTING
//  T1: file_size=8, LANES=4, beats 0x41414141,0x42414241 -> done 1 cycle after beat 2.
//    bin[0x41]=6, bin[0x42]=2, leaf_count=2, byte_count=8.
//  T2: file_size=5, beats 0x04030201,0xFFFFFF05 -> bins 1..5 = 1 each, bin[0xFF]=0, done, in_ready low afterwards.
//  T3: file_size=0 start -> done next cycle, all bins 0, leaf_count=0, in_ready never high.
//  T4: start, 1 beat accepted, clear with in_valid held high -> IDLE, bins 0, byte_count 0, no further beats accepted.
//  T5: CNT_W=4, 20 beats of 0x07070707, file_size=80 -> SATURATE_EN: bin[7]=15, sat_flag=1.
//    Without the macro: bin[7]=80 mod 16=0, sat_flag=0.
//  T6: reset asserted mid-ACCUM -> all outputs 0 immediately. Then rd_addr sweep 0..255 returns 0 with 1-cycle latency.

Source files
------------

// File: rtl/huffman_hist_accum.sv
// Symbol-frequency histogram for the Huffman front end: counts file_size symbols, LANES per beat.
// Optional bin saturation and sticky sat_flag are enabled by defining HUFF_HIST_SATURATE_EN.
module huffman_hist_accum #(
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 16,
    parameter int LANES  = 4,
    parameter int SIZE_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic [SIZE_W-1:0]        file_size,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*SYM_W-1:0]   in_data,
    output logic                     busy,
    output logic                     done,
    output logic [SIZE_W-1:0]        byte_count,
    output logic [SYM_W:0]           leaf_count,
    input  logic [SYM_W-1:0]         rd_addr,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     sat_flag
);

    localparam int NBINS  = 1 << SYM_W;
    localparam int LANE_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  remaining_q, remaining_d;
    logic [SIZE_W-1:0]  byte_count_q, byte_count_d;
    logic [CNT_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]   bins_q   [NBINS];
    logic [CNT_W-1:0]   bins_d   [NBINS];
    logic [CNT_W-1:0]   bins_upd [NBINS];

    logic               beat_fire;
    logic [LANE_W-1:0]  take;
    logic [LANES-1:0]   lane_en;
    logic [SYM_W-1:0]   lane_sym [LANES];
    logic [LANE_W-1:0]  hits;
    logic [SYM_W:0]     leaf_cnt;

`ifdef HUFF_HIST_SATURATE_EN
    localparam logic [CNT_W+LANE_W-1:0] BIN_MAX = {{LANE_W{1'b0}}, {CNT_W{1'b1}}};
    logic [CNT_W+LANE_W-1:0] sum;
    logic                    sat_hit;
    logic                    sat_q, sat_d;
`endif

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q == S_ACCUM);
    assign done      = (state_q == S_DONE);
    assign beat_fire = in_valid && in_ready;

    // The final beat may be partial: only the first `take` lanes belong to the file.
    always_comb begin
        if (remaining_q >= SIZE_W'(LANES)) begin
            take = LANE_W'(LANES);
        end else begin
            take = remaining_q[LANE_W-1:0];
        end
        for (int k = 0; k < LANES; k++) begin
            lane_sym[k] = in_data[k*SYM_W +: SYM_W];
            lane_en[k]  = beat_fire && (LANE_W'(k) < take);
        end
    end

    // NOTE: every variable gets a value before any branch reads or skips it, so no latches form.
    always_comb begin
        hits = '0;
`ifdef HUFF_HIST_SATURATE_EN
        sum     = '0;
        sat_hit = 1'b0;
`endif
        for (int b = 0; b < NBINS; b++) begin
            hits = '0;
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k] && (lane_sym[k] == SYM_W'(b))) begin
                    hits = hits + LANE_W'(1);
                end
            end
`ifdef HUFF_HIST_SATURATE_EN
            sum = {{LANE_W{1'b0}}, bins_q[b]} + (CNT_W+LANE_W)'(hits);
            if (sum > BIN_MAX) begin
                bins_upd[b] = '1;
                sat_hit     = 1'b1;
            end else begin
                bins_upd[b] = sum[CNT_W-1:0];
            end
`else
            bins_upd[b] = bins_q[b] + CNT_W'(hits);
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        byte_count_d = byte_count_q;
        for (int b = 0; b < NBINS; b++) begin
            bins_d[b] = bins_q[b];
        end

        if (clear) begin
            state_d      = S_IDLE;
            remaining_d  = '0;
            byte_count_d = '0;
            for (int b = 0; b < NBINS; b++) begin
                bins_d[b] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        remaining_d  = file_size;
                        byte_count_d = '0;
                        for (int b = 0; b < NBINS; b++) begin
                            bins_d[b] = '0;
                        end
                        state_d = (file_size == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (beat_fire) begin
                        for (int b = 0; b < NBINS; b++) begin
                            bins_d[b] = bins_upd[b];
                        end
                        remaining_d  = remaining_q - SIZE_W'(take);
                        byte_count_d = byte_count_q + SIZE_W'(take);
                        if (remaining_q == SIZE_W'(take)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: the bins are flops, not a RAM: all of them reset, clear and update in a single cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            byte_count_q <= '0;
            rd_data_q    <= '0;
            for (int b = 0; b < NBINS; b++) begin
                bins_q[b] <= '0;
            end
        end else begin
            // NOTE: non-blocking, so rd_data samples the pre-update bin on the same edge.
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            byte_count_q <= byte_count_d;
            rd_data_q    <= bins_q[rd_addr];
            for (int b = 0; b < NBINS; b++) begin
                bins_q[b] <= bins_d[b];
            end
        end
    end

`ifdef HUFF_HIST_SATURATE_EN
    always_comb begin
        sat_d = sat_q | sat_hit;
        if (clear || (start && (state_q != S_ACCUM))) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        leaf_cnt = '0;
        for (int b = 0; b < NBINS; b++) begin
            if (bins_q[b] != '0) begin
                leaf_cnt = leaf_cnt + (SYM_W+1)'(1);
            end
        end
    end

    assign leaf_count = leaf_cnt;
    assign byte_count = byte_count_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_huffman_hist_accum.sv
// Self-checking bench for huffman_hist_accum: a symbol-level histogram model checked every cycle,
// plus directed scenarios with hand-computed bin values (CNT_W=4 so saturation/wrap is reachable).
module tb_huffman_hist_accum;

    localparam int SYM_W  = 8;
    localparam int CNT_W  = 4;
    localparam int LANES  = 4;
    localparam int SIZE_W = 16;
    localparam int NBINS  = 1 << SYM_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                   clk       = 1'b0;
    logic                   reset     = 1'b0;
    logic                   clear     = 1'b0;
    logic                   start     = 1'b0;
    logic [SIZE_W-1:0]      file_size = '0;
    logic                   in_valid  = 1'b0;
    logic [LANES*SYM_W-1:0] in_data   = '0;
    logic [SYM_W-1:0]       rd_addr   = '0;
    logic                   in_ready;
    logic                   busy;
    logic                   done;
    logic [SIZE_W-1:0]      byte_count;
    logic [SYM_W:0]         leaf_count;
    logic [CNT_W-1:0]       rd_data;
    logic                   sat_flag;

    huffman_hist_accum #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W),
        .LANES (LANES),
        .SIZE_W(SIZE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .file_size (file_size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .done      (done),
        .byte_count(byte_count),
        .leaf_count(leaf_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one symbol at a time in file order ----------------
    typedef enum {P_IDLE, P_ACCUM, P_DONE} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_bin [NBINS];
    int     m_rem = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    int     m_rd  = 0;

    function automatic int m_leaf();
        int n = 0;
        for (int b = 0; b < NBINS; b++) if (m_bin[b] != 0) n++;
        return n;
    endfunction

    task automatic m_zero();
        for (int b = 0; b < NBINS; b++) m_bin[b] = 0;
    endtask

    task automatic m_count_symbol(input int s);
`ifdef HUFF_HIST_SATURATE_EN
        if (m_bin[s] == CMAX) m_sat = 1'b1;
        else m_bin[s] = m_bin[s] + 1;
`else
        m_bin[s] = (m_bin[s] + 1) % (CMAX + 1);
`endif
    endtask

    task automatic m_step();
        if (!reset) begin
            m_zero();
            m_phase = P_IDLE;
            m_rem = 0; m_cnt = 0; m_sat = 1'b0; m_rd = 0;
        end else begin
            m_rd = m_bin[rd_addr];
            if (clear) begin
                m_zero();
                m_phase = P_IDLE;
                m_rem = 0; m_cnt = 0; m_sat = 1'b0;
            end else if (start && m_phase != P_ACCUM) begin
                m_zero();
                m_rem = int'(file_size); m_cnt = 0; m_sat = 1'b0;
                m_phase = (file_size == 0) ? P_DONE : P_ACCUM;
            end else if (m_phase == P_ACCUM && in_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    if (m_rem > 0) begin
                        m_count_symbol(int'(in_data[k*SYM_W +: SYM_W]));
                        m_rem--;
                        m_cnt++;
                    end
                end
                if (m_rem == 0) m_phase = P_DONE;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        m_step();
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("cyc_in_ready",   in_ready,   (m_phase == P_ACCUM));
            check("cyc_busy",       busy,       (m_phase == P_ACCUM));
            check("cyc_done",       done,       (m_phase == P_DONE));
            check("cyc_byte_count", byte_count, m_cnt);
            check("cyc_leaf_count", leaf_count, m_leaf());
            check("cyc_rd_data",    rd_data,    m_rd);
            check("cyc_sat_flag",   sat_flag,   m_sat);
        end
    end

    // ---------------- stimulus helpers (each entered and left just after a negedge) ----------------
    task automatic do_start(input int size);
        start = 1'b1;
        file_size = SIZE_W'(size);
        @(negedge clk);
        start = 1'b0;
        file_size = SIZE_W'($urandom);
    endtask

    task automatic beat(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_ready_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic read_bin(input int addr, output logic [CNT_W-1:0] val);
        rd_addr = SYM_W'(addr);
        @(negedge clk);
        val = rd_data;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [CNT_W-1:0] v;

        #1;
        check("rst_in_ready",   in_ready,   0);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_byte_count", byte_count, 0);
        check("rst_leaf_count", leaf_count, 0);
        check("rst_rd_data",    rd_data,    0);
        check("rst_sat_flag",   sat_flag,   0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // T1: two full beats with repeated symbols
        do_start(8);
        check("t1_busy_after_start", busy, 1);
        beat(32'h41414141);
        beat(32'h42414241);
        check("t1_done",       done,       1);
        check("t1_byte_count", byte_count, 8);
        check("t1_leaf_count", leaf_count, 2);
        read_bin(8'h41, v); check("t1_bin41", v, 6);
        read_bin(8'h42, v); check("t1_bin42", v, 2);

        // T2: partial last beat, upper lanes ignored
        do_start(5);
        check("t2_bins_cleared_leaf", leaf_count, 0);
        beat(32'h04030201);
        beat(32'hFFFFFF05);
        check("t2_done",       done,       1);
        check("t2_in_ready",   in_ready,   0);
        check("t2_byte_count", byte_count, 5);
        check("t2_leaf_count", leaf_count, 5);
        for (int s = 1; s <= 5; s++) begin
            read_bin(s, v);
            check("t2_bin_1to5", v, 1);
        end
        read_bin(8'hFF, v); check("t2_binFF", v, 0);
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("t2_byte_count_held", byte_count, 5);

        // T3: zero-length run from IDLE
        pulse_clear();
        check("t3_idle_done", done, 0);
        do_start(0);
        check("t3_done",       done,       1);
        check("t3_busy",       busy,       0);
        check("t3_leaf_count", leaf_count, 0);
        check("t3_byte_count", byte_count, 0);
        read_bin(8'h41, v); check("t3_bin41", v, 0);

        // T4: clear wins over a pending beat and returns to IDLE
        do_start(16);
        beat(32'h01020304);
        check("t4_byte_count_mid", byte_count, 4);
        in_valid = 1'b1; in_data = 32'h09090909;
        pulse_clear();
        check("t4_in_ready",   in_ready,   0);
        check("t4_busy",       busy,       0);
        check("t4_byte_count", byte_count, 0);
        check("t4_leaf_count", leaf_count, 0);
        repeat (3) @(negedge clk);
        check("t4_byte_count_held", byte_count, 0);
        read_bin(8'h09, v); check("t4_bin09", v, 0);
        in_valid = 1'b0;

        // T5: 80 copies of symbol 7 into a 4-bit bin
        do_start(80);
        for (int i = 0; i < 20; i++) beat(32'h07070707);
        check("t5_done",       done,       1);
        check("t5_byte_count", byte_count, 80);
        read_bin(7, v);
`ifdef HUFF_HIST_SATURATE_EN
        check("t5_bin7_sat",   v,          15);
        check("t5_sat_flag",   sat_flag,   1);
        check("t5_leaf_count", leaf_count, 1);
`else
        check("t5_bin7_wrap",  v,          0);
        check("t5_sat_flag",   sat_flag,   0);
        check("t5_leaf_count", leaf_count, 0);
`endif
        do_start(4);
        check("t5_sat_cleared_by_start", sat_flag, 0);
        beat(32'h03020100);
        check("t5_second_run_done", done, 1);
        check("t5_second_run_leaf", leaf_count, 4);

        // T6: asynchronous reset mid-run, then a full readout sweep
        do_start(12);
        beat(32'h0A0B0C0D);
        check("t6_busy_before_reset", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_in_ready",   in_ready,   0);
        check("t6_busy",       busy,       0);
        check("t6_done",       done,       0);
        check("t6_byte_count", byte_count, 0);
        check("t6_leaf_count", leaf_count, 0);
        check("t6_rd_data",    rd_data,    0);
        check("t6_sat_flag",   sat_flag,   0);
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < NBINS; a++) begin
            read_bin(a, v);
            check("t6_sweep", v, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
